lc3b_fwd_ctrl: RTL and testbench

- Operand-forwarding and load-use hazard controller for the 5-stage LC-3b pipeline.
- Keeps a private shadow pipeline of destination tags for the EX, MEM and WB stages.
- Drives the lc3b_mux_sel selects of the two EX-stage operand 3:1 muxes: register file, EX/MEM result, or MEM/WB result.
- Asserts a one-cycle load-use stall that freezes IF/ID and injects a bubble into EX.

---
 rtl/lc3b_types.sv | 38 +++
 rtl/lc3b_fwd_pick.sv | 37 +++
 rtl/lc3b_fwd_ctrl.sv | 138 +++++++++++++
 tb/tb_lc3b_fwd_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared types and constants for the LC-3b forwarding controller
//
// Contents:
//   lc3b_mux_sel  : 2-bit select for the EX-stage operand 3:1 muxes
//   FWD_*         : select encodings (regfile, EX/MEM result, MEM/WB result)
//   lc3b_reg      : architectural register index
//   lc3b_fwd_tag  : per-stage destination tag {valid, wr, is_load, dest}
//   tag_hit()     : true when a stage tag produces the given source register

package lc3b_types;

  localparam int unsigned LC3B_NREG = 8;
  localparam int unsigned LC3B_RW   = 3;

  typedef logic [1:0] lc3b_mux_sel;

  localparam lc3b_mux_sel FWD_REGFILE = 2'b00;
  localparam lc3b_mux_sel FWD_EXMEM   = 2'b01;
  localparam lc3b_mux_sel FWD_MEMWB   = 2'b10;

  typedef logic [LC3B_RW-1:0] lc3b_reg;

  typedef struct packed {
    logic    valid;
    logic    wr;
    logic    is_load;
    lc3b_reg dest;
  } lc3b_fwd_tag;

  localparam lc3b_fwd_tag FWD_TAG_BUBBLE = '0;

  // A bubble or a non-writing instruction never produces a value, whatever
  // its dest field happens to hold.
  function automatic logic tag_hit(input lc3b_fwd_tag tag, input lc3b_reg src);
    return tag.valid & tag.wr & (tag.dest == src);
  endfunction

endpackage

// File: rtl/lc3b_fwd_pick.sv
// rtl/lc3b_fwd_pick.sv - forward-source picker for one EX operand
//
// Ports:
//   en       in   EX holds a real instruction that reads this operand
//   src      in   source register index of the operand
//   mem_tag  in   destination tag of the instruction in MEM
//   wb_tag   in   destination tag of the instruction in WB
//   sel      out  operand mux select (regfile / EX-MEM / MEM-WB)

module lc3b_fwd_pick
  import lc3b_types::*;
(
  input  logic        en,
  input  lc3b_reg     src,
  input  lc3b_fwd_tag mem_tag,
  input  lc3b_fwd_tag wb_tag,
  output lc3b_mux_sel sel
);

  // Load-ness does not affect the choice here; the load-use stall keeps a
  // load in MEM from ever being the producer of an EX operand.
  logic unused_is_load;
  assign unused_is_load = mem_tag.is_load ^ wb_tag.is_load;

  // MEM is checked first: it holds the younger of two writers to src.
  always_comb begin
    sel = FWD_REGFILE;
    if (en) begin
      if (tag_hit(mem_tag, src)) begin
        sel = FWD_EXMEM;
      end else if (tag_hit(wb_tag, src)) begin
        sel = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/lc3b_fwd_ctrl.sv
// rtl/lc3b_fwd_ctrl.sv - operand forwarding and load-use hazard control, LC-3b 5-stage pipe
//
// Keeps a shadow pipeline of destination tags for EX, MEM and WB and derives
// the EX operand mux selects and a one-cycle load-use stall from it.
//
// Ports:
//   clk, rst_n          pipeline clock, asynchronous active-low reset
//   pipe_stall          global freeze; all shadow stages hold
//   id_valid            ID holds a real instruction
//   id_sr1, id_sr2      ID source registers
//   id_sr1_used/_used   instruction actually reads sr1 / sr2
//   id_dest, id_wr      ID destination and register-write enable
//   id_is_load          instruction is LDR/LDB/LDI
//   fwd_sel_a/_b        EX operand A/B mux selects
//   load_use_stall      hold PC and IF/ID, bubble into EX
//
// Optional (macro LC3B_FWD_STATS_EN):
//   fwd_count           advancing cycles with a nonzero select (saturating)
//   stall_count         cycles with load_use_stall asserted (saturating)

module lc3b_fwd_ctrl
  import lc3b_types::*;
#(
  parameter int unsigned NREG = LC3B_NREG,
  parameter int unsigned RW   = LC3B_RW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pipe_stall,
  input  logic          id_valid,
  input  logic [RW-1:0] id_sr1,
  input  logic [RW-1:0] id_sr2,
  input  logic          id_sr1_used,
  input  logic          id_sr2_used,
  input  logic [RW-1:0] id_dest,
  input  logic          id_wr,
  input  logic          id_is_load,
  output logic [1:0]    fwd_sel_a,
  output logic [1:0]    fwd_sel_b,
  output logic          load_use_stall
`ifdef LC3B_FWD_STATS_EN
  ,
  output logic [31:0]   fwd_count,
  output logic [31:0]   stall_count
`endif
);

  lc3b_fwd_tag ex_q;
  lc3b_fwd_tag mem_q;
  lc3b_fwd_tag wb_q;
  lc3b_reg     ex_sr1;
  lc3b_reg     ex_sr2;
  logic        ex_sr1_used;
  logic        ex_sr2_used;

  // An index beyond the architectural file cannot name a real register, so
  // it is treated as a non-writer rather than aliasing a low register.
  logic id_dest_ok;
  assign id_dest_ok = (32'(id_dest) < NREG);

  logic id_hits_ex_load;
  assign id_hits_ex_load = (id_sr1_used & (id_sr1 == ex_q.dest)) |
                           (id_sr2_used & (id_sr2 == ex_q.dest));

  // Memory freeze wins: nothing advances, so there is nothing to bubble.
  assign load_use_stall = ~pipe_stall & id_valid & ex_q.valid & ex_q.wr &
                          ex_q.is_load & id_hits_ex_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= FWD_TAG_BUBBLE;
      mem_q       <= FWD_TAG_BUBBLE;
      wb_q        <= FWD_TAG_BUBBLE;
      ex_sr1      <= '0;
      ex_sr2      <= '0;
      ex_sr1_used <= 1'b0;
      ex_sr2_used <= 1'b0;
    end else if (!pipe_stall) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (load_use_stall) begin
        ex_q        <= FWD_TAG_BUBBLE;
        ex_sr1_used <= 1'b0;
        ex_sr2_used <= 1'b0;
      end else begin
        ex_q.valid   <= id_valid;
        ex_q.wr      <= id_wr & id_dest_ok;
        ex_q.is_load <= id_is_load;
        ex_q.dest    <= id_dest;
        ex_sr1       <= id_sr1;
        ex_sr2       <= id_sr2;
        ex_sr1_used  <= id_sr1_used;
        ex_sr2_used  <= id_sr2_used;
      end
    end
  end

  lc3b_fwd_pick u_pick_a (
    .en      (ex_q.valid & ex_sr1_used),
    .src     (ex_sr1),
    .mem_tag (mem_q),
    .wb_tag  (wb_q),
    .sel     (fwd_sel_a)
  );

  lc3b_fwd_pick u_pick_b (
    .en      (ex_q.valid & ex_sr2_used),
    .src     (ex_sr2),
    .mem_tag (mem_q),
    .wb_tag  (wb_q),
    .sel     (fwd_sel_b)
  );

  // A load in MEM has no data yet; selecting EX/MEM for it means the
  // load-use stall failed to separate producer and consumer.
  a_no_mem_load_fwd : assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_q.is_load && (fwd_sel_a == FWD_EXMEM || fwd_sel_b == FWD_EXMEM)));

`ifdef LC3B_FWD_STATS_EN
  logic fwd_any;
  assign fwd_any = (fwd_sel_a != FWD_REGFILE) | (fwd_sel_b != FWD_REGFILE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_count   <= '0;
      stall_count <= '0;
    end else if (!pipe_stall) begin
      if (fwd_any && fwd_count != '1) begin
        fwd_count <= fwd_count + 32'd1;
      end
      if (load_use_stall && stall_count != '1) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lc3b_fwd_ctrl.sv
// tb/tb_lc3b_fwd_ctrl.sv - directed vector bench for lc3b_fwd_ctrl

module tb_lc3b_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pipe_stall;
  logic       id_valid;
  logic [2:0] id_sr1;
  logic [2:0] id_sr2;
  logic       id_sr1_used;
  logic       id_sr2_used;
  logic [2:0] id_dest;
  logic       id_wr;
  logic       id_is_load;
  logic [1:0] fwd_sel_a;
  logic [1:0] fwd_sel_b;
  logic       load_use_stall;
`ifdef LC3B_FWD_STATS_EN
  logic [31:0] fwd_count;
  logic [31:0] stall_count;
`endif

  always #5 clk = ~clk;

  lc3b_fwd_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pipe_stall     (pipe_stall),
    .id_valid       (id_valid),
    .id_sr1         (id_sr1),
    .id_sr2         (id_sr2),
    .id_sr1_used    (id_sr1_used),
    .id_sr2_used    (id_sr2_used),
    .id_dest        (id_dest),
    .id_wr          (id_wr),
    .id_is_load     (id_is_load),
    .fwd_sel_a      (fwd_sel_a),
    .fwd_sel_b      (fwd_sel_b),
    .load_use_stall (load_use_stall)
`ifdef LC3B_FWD_STATS_EN
    ,
    .fwd_count      (fwd_count),
    .stall_count    (stall_count)
`endif
  );

  typedef struct {
    logic       ps;
    logic       v;
    logic [2:0] s1;
    logic [2:0] s2;
    logic       u1;
    logic       u2;
    logic [2:0] d;
    logic       w;
    logic       l;
    logic [1:0] ea;
    logic [1:0] eb;
    logic       es;
  } vec_t;

  vec_t tv[31];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic ps, input logic v,
                              input logic [2:0] s1, input logic [2:0] s2,
                              input logic u1, input logic u2,
                              input logic [2:0] d, input logic w, input logic l,
                              input logic [1:0] ea, input logic [1:0] eb,
                              input logic es);
    vec_t x;
    x.ps = ps; x.v = v; x.s1 = s1; x.s2 = s2; x.u1 = u1; x.u2 = u2;
    x.d = d; x.w = w; x.l = l; x.ea = ea; x.eb = eb; x.es = es;
    return x;
  endfunction

  function automatic vec_t nop(input logic [1:0] ea, input logic [1:0] eb);
    return mk(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, ea, eb, 1'b0);
  endfunction

  task automatic drive(input vec_t x);
    pipe_stall  = x.ps;
    id_valid    = x.v;
    id_sr1      = x.s1;
    id_sr2      = x.s2;
    id_sr1_used = x.u1;
    id_sr2_used = x.u2;
    id_dest     = x.d;
    id_wr       = x.w;
    id_is_load  = x.l;
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input int idx, input logic [1:0] ea,
                         input logic [1:0] eb, input logic es);
    chk({name, ".sel_a"}, idx, 32'(fwd_sel_a), 32'(ea));
    chk({name, ".sel_b"}, idx, 32'(fwd_sel_b), 32'(eb));
    chk({name, ".stall"}, idx, 32'(load_use_stall), 32'(es));
  endtask

  initial begin
    // Each row: ID contents for one cycle and the outputs expected during
    // that cycle, before the following rising edge.
    // back-to-back: ADD R1<-R2+R3 ; ADD R4<-R1+R1
    tv[0]  = mk(0, 1, 2, 3, 1, 1, 1, 1, 0, 0, 0, 0);
    tv[1]  = mk(0, 1, 1, 1, 1, 1, 4, 1, 0, 0, 0, 0);
    tv[2]  = nop(2'b01, 2'b01);
    tv[3]  = nop(2'b00, 2'b00);
    // two apart: ADD R1 ; NOP ; AND R5<-R1,R6
    tv[4]  = mk(0, 1, 2, 3, 1, 1, 1, 1, 0, 0, 0, 0);
    tv[5]  = nop(2'b00, 2'b00);
    tv[6]  = mk(0, 1, 1, 6, 1, 1, 5, 1, 0, 0, 0, 0);
    tv[7]  = nop(2'b10, 2'b00);
    // double producer: ADD R2 ; ADD R2 ; ADD R3<-R2,R7
    tv[8]  = mk(0, 1, 0, 0, 1, 1, 2, 1, 0, 0, 0, 0);
    tv[9]  = mk(0, 1, 4, 4, 1, 1, 2, 1, 0, 0, 0, 0);
    tv[10] = mk(0, 1, 2, 7, 1, 1, 3, 1, 0, 0, 0, 0);
    tv[11] = nop(2'b01, 2'b00);
    // bubble carrying dest R6 with wr set, then a reader of R6
    tv[12] = mk(0, 0, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0);
    tv[13] = mk(0, 1, 6, 6, 1, 1, 0, 1, 0, 0, 0, 0);
    tv[14] = nop(2'b00, 2'b00);
    tv[15] = nop(2'b00, 2'b00);
    // load-use: LDR R1<-[R2] ; ADD R2<-R1+R3 (held one cycle)
    tv[16] = mk(0, 1, 2, 0, 1, 0, 1, 1, 1, 0, 0, 0);
    tv[17] = mk(0, 1, 1, 3, 1, 1, 2, 1, 0, 0, 0, 1);
    tv[18] = mk(0, 1, 1, 3, 1, 1, 2, 1, 0, 0, 0, 0);
    tv[19] = nop(2'b10, 2'b00);
    // load followed by an instruction naming the load dest in an unused field
    tv[20] = mk(0, 1, 5, 0, 1, 0, 4, 1, 1, 0, 0, 0);
    tv[21] = mk(0, 1, 4, 6, 0, 1, 0, 0, 0, 0, 0, 0);
    tv[22] = nop(2'b00, 2'b00);
    tv[23] = nop(2'b00, 2'b00);
    // freeze for 3 cycles while LDR R1 -> ADD R2<-R3+R1 is pending
    tv[24] = mk(0, 1, 2, 0, 1, 0, 1, 1, 1, 0, 0, 0);
    tv[25] = mk(1, 1, 3, 1, 1, 1, 2, 1, 0, 0, 0, 0);
    tv[26] = mk(1, 1, 3, 1, 1, 1, 2, 1, 0, 0, 0, 0);
    tv[27] = mk(1, 1, 3, 1, 1, 1, 2, 1, 0, 0, 0, 0);
    tv[28] = mk(0, 1, 3, 1, 1, 1, 2, 1, 0, 0, 0, 1);
    tv[29] = mk(0, 1, 3, 1, 1, 1, 2, 1, 0, 0, 0, 0);
    tv[30] = nop(2'b00, 2'b10);

    rst_n = 1'b0;
    drive(nop(2'b00, 2'b00));
    @(negedge clk);
    #1;
    chk_out("reset", 0, 2'b00, 2'b00, 1'b0);
`ifdef LC3B_FWD_STATS_EN
    chk("reset.fwd_count", 0, fwd_count, 32'd0);
    chk("reset.stall_count", 0, stall_count, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 31; i++) begin
      drive(tv[i]);
      #1;
      chk_out("vec", i, tv[i].ea, tv[i].eb, tv[i].es);
      @(negedge clk);
    end

`ifdef LC3B_FWD_STATS_EN
    chk("stats.fwd_count", 0, fwd_count, 32'd5);
    chk("stats.stall_count", 0, stall_count, 32'd2);
`endif

    // Reset mid-stream: ADD R1 reaches MEM while LDR R5 in EX stalls a reader.
    drive(mk(0, 1, 2, 3, 1, 1, 1, 1, 0, 0, 0, 0));
    @(negedge clk);
    drive(mk(0, 1, 6, 0, 1, 0, 5, 1, 1, 0, 0, 0));
    @(negedge clk);
    drive(mk(0, 1, 5, 1, 1, 1, 4, 1, 0, 0, 0, 0));
    #1;
    chk_out("pre_reset", 0, 2'b00, 2'b00, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("in_reset", 0, 2'b00, 2'b00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk(0, 1, 1, 5, 1, 1, 4, 1, 0, 0, 0, 0));
    #1;
    chk_out("post_reset_id", 0, 2'b00, 2'b00, 1'b0);
    @(negedge clk);
    drive(nop(2'b00, 2'b00));
    #1;
    chk_out("post_reset_ex", 0, 2'b00, 2'b00, 1'b0);
`ifdef LC3B_FWD_STATS_EN
    chk("post_reset.fwd_count", 0, fwd_count, 32'd0);
    chk("post_reset.stall_count", 0, stall_count, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
